out_uart_tx: RTL and testbench
==============================

# out_uart_tx

Output stage directly downstream of the 4-bit ALU/accumulator result bus. It captures result words on a strobe, buffers them in a small FIFO, and serialises each one as an 8N1 UART frame on a single `tx` pin, so program results can be observed on a host terminal. It contains no processor state and only consumes the result word and a valid strobe.

## Interface
- `BIT_WIDTH`, 4: width of captured result word; legal range 1..8.
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥2.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `data_in`, in, BIT_WIDTH: result word from the ALU output bus.
- `data_valid`, in, 1: capture strobe; `data_in` is pushed in every cycle this is high.
- `tx`, out, 1: UART serial output; idle high.
- `busy`, out, 1: high while a frame is on the line (states START/DATA/STOP).
- `fifo_full`, out, 1: FIFO holds FIFO_DEPTH entries.
- `fifo_empty`, out, 1: FIFO holds 0 entries.
- `drop_count`, out, 8: number of words dropped on overflow; saturates at 255.

## Operation
- Reset values: `tx`=1, `busy`=0, `fifo_full`=0, `fifo_empty`=1, `drop_count`=0, FSM=IDLE, FIFO pointers and count=0. Reset mid-frame aborts the frame immediately (`tx` high the next cycle) and discards FIFO contents.
- Push: `data_valid`=1 and FIFO not full → word written at the write pointer, count +1.
- Overflow: `data_valid`=1 and full with no pop in the same cycle → word discarded, `drop_count` +1, saturating at 255.
- Simultaneous push and pop: always accepted, even when full, and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are derived from a count register of width log2(FIFO_DEPTH)+1.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first, for CLKS_PER_BIT cycles per bit. After bit 7 go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle, pop and go to START if the FIFO is non-empty, otherwise go to IDLE.
- Frame byte: `data_in` zero-extended to 8 bits, unless the hex conversion in Configuration is compiled in.
- The baud counter counts 0..CLKS_PER_BIT-1 and resets on every state entry.

## Timing
- A push in cycle N is visible in `fifo_empty` at N+1.
- Empty FIFO, IDLE, push at cycle N: pop at N+1, START entered and `tx` falls at N+2.
- Frame length is exactly 10×CLKS_PER_BIT cycles from the `tx` falling edge to the end of the stop bit.
- Back-to-back frames have no idle gap: the next start bit begins the cycle after the last stop-bit cycle.
- `busy` is registered and aligned with `tx`: high exactly during the frame cycles.
- A pop taken at the end of STOP frees a slot in the same cycle, so a push in that cycle is accepted even if the FIFO was full.

## Configuration
- `OUT_UART_HEX_EN` defined: the frame byte is the ASCII hex digit of `data_in[3:0]`.
  - 0–9 map to 0x30–0x39; 10–15 map to 0x41–0x46.
  - Bits above 3 are ignored; BIT_WIDTH<4 is zero-extended before conversion.
- `OUT_UART_HEX_EN` undefined: raw zero-extended byte, and no conversion logic is present.

## Test plan
Parameters for all scenarios: CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset: hold `rst` 3 cycles with `data_valid` toggling → `tx`=1, `busy`=0, `fifo_empty`=1, `drop_count`=0 throughout.
- Single word: push `data_in`=0xA at cycle N → `tx` falls at N+2. Decoded frame is 0x0A raw, or 0x41 with `OUT_UART_HEX_EN`. Frame is 40 cycles long; `busy` is high for 40 cycles.
- Back-to-back: push 0x3 then 0x5 on consecutive cycles → two frames with 0 idle cycles between. Decoded 0x03, 0x05 (hex build: 0x33, 0x35).
- Overflow: with TX busy, push 7 words 0x1..0x7 in 7 consecutive cycles → 0x2–0x5 fill the FIFO (0x1 went straight to the shifter); 0x6 and 0x7 are dropped and `drop_count`=2. Output order is 0x1..0x5.
- Full plus simultaneous pop: with the FIFO full, push exactly on the last STOP cycle → word accepted, `fifo_full` stays 1, `drop_count` unchanged.
- Reset mid-frame: assert `rst` during DATA bit 3 → `tx`=1 the next cycle, FIFO empty, no further frames.

Source files
------------

// File: rtl/out_uart_tx.sv
// out_uart_tx: captures ALU result words into a small FIFO and sends each one as an 8N1 UART frame.
// Optional OUT_UART_HEX_EN: send the ASCII hex digit of data_in[3:0] instead of the raw zero-extended word.
module out_uart_tx #(
    parameter int BIT_WIDTH    = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] data_in,
    input  logic                 data_valid,
    output logic                 tx,
    output logic                 busy,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic [7:0]           drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        baud;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;

    logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;

    logic                 baud_done;
    logic                 pop;
    logic                 push;
    logic [7:0]           head_byte;

    assign baud_done  = (baud == BAUD_LAST);
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // The FSM pops while idle, or on the final stop-bit cycle to chain frames with no gap.
    assign pop  = !fifo_empty && ((state == IDLE) || (state == STOP && baud_done));
    // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
    assign push = data_valid && (!fifo_full || pop);

`ifdef OUT_UART_HEX_EN
    logic [3:0] head_nib;
    assign head_nib  = 4'(8'(mem[rd_ptr]));
    assign head_byte = (head_nib < 4'd10) ? (8'h30 + {4'h0, head_nib})
                                          : (8'h37 + {4'h0, head_nib});
`else
    assign head_byte = 8'(mem[rd_ptr]);
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
            if (data_valid && !push && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // tx and busy are registered alongside the state so they line up with the frame exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pop) begin
                        shift <= head_byte;
                        state <= START;
                        baud  <= '0;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state   <= DATA;
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= head_byte;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: queue/frame-position reference model, a UART line decoder, directed and random stimulus.
module tb_out_uart_tx;
    localparam int BW    = 4;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FLEN  = 10 * CPB;

`ifdef OUT_UART_HEX_EN
    localparam logic [7:0] LIT_A    = 8'h41;
    localparam logic [7:0] LIT_3    = 8'h33;
    localparam logic [7:0] LIT_5    = 8'h35;
    localparam logic [7:0] LIT_BASE = 8'h30;
`else
    localparam logic [7:0] LIT_A    = 8'h0A;
    localparam logic [7:0] LIT_3    = 8'h03;
    localparam logic [7:0] LIT_5    = 8'h05;
    localparam logic [7:0] LIT_BASE = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          data_valid;
    logic [BW-1:0] data_in;
    logic          tx;
    logic          busy;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    drop_count;

    out_uart_tx #(.BIT_WIDTH(BW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .tx(tx), .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Reference model: a word queue plus the position inside the frame currently on the line.
    int            cyc = 0;
    logic [BW-1:0] mq[$];
    logic [7:0]    exp_q[$];
    logic [7:0]    dec_q[$];
    int            fall_q[$];
    bit            m_active = 1'b0;
    int            m_pos = 0;
    logic [7:0]    m_byte = 8'h00;
    int            m_drop = 0;
    bit            m_take;

    function automatic logic [7:0] frame_byte(input logic [BW-1:0] d);
`ifdef OUT_UART_HEX_EN
        return (d < 10) ? 8'h30 + 8'(d) : 8'h41 + 8'(d) - 8'd10;
`else
        return 8'(d);
`endif
    endfunction

    function automatic logic exp_tx();
        if (!m_active)       return 1'b1;
        if (m_pos < CPB)     return 1'b0;
        if (m_pos < 9 * CPB) return m_byte[3'((m_pos - CPB) / CPB)];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (m_active && m_pos != FLEN - 1) exp_q.delete(exp_q.size() - 1);
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_drop   = 0;
        end else begin
            m_take = (mq.size() != 0) && (!m_active || m_pos == FLEN - 1);
            if (m_active) begin
                if (m_pos == FLEN - 1) m_active = 1'b0;
                else m_pos++;
            end
            if (m_take) begin
                m_byte   = frame_byte(mq.pop_front());
                m_active = 1'b1;
                m_pos    = 0;
                exp_q.push_back(m_byte);
            end
            if (data_valid) begin
                if (mq.size() < DEPTH) mq.push_back(data_in);
                else if (m_drop < 255) m_drop++;
            end
        end
    end

    logic [11:0] cmp_got;
    logic [11:0] cmp_exp;
    always @(negedge clk) begin
        if (cyc > 0) begin
            cmp_got = {tx, busy, fifo_full, fifo_empty, drop_count};
            cmp_exp = {exp_tx(), m_active, 1'(mq.size() == DEPTH), 1'(mq.size() == 0), 8'(m_drop)};
            chk("cycle_model {tx,busy,full,empty,drops}", 32'(cmp_got), 32'(cmp_exp));
        end
    end

    // Line decoder: samples mid-bit, records start-bit cycles and completed bytes.
    bit         in_frame = 1'b0;
    int         fs = 0;
    int         off;
    logic [7:0] db;
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    fs = cyc;
                    db = 8'h00;
                    fall_q.push_back(cyc);
                end
            end else begin
                off = cyc - fs;
                if (off >= CPB && off < 9 * CPB && (off % CPB) == CPB / 2)
                    db[3'((off - CPB) / CPB)] = tx;
                if (off == FLEN - 1) begin
                    dec_q.push_back(db);
                    in_frame = 1'b0;
                end
            end
        end
    end

    function automatic int fall_at(input int i);
        return (i < fall_q.size()) ? fall_q[i] : -1;
    endfunction

    function automatic int dec_at(input int i);
        return (i < dec_q.size()) ? int'(dec_q[i]) : -1;
    endfunction

    task automatic apply(input logic r, input logic v, input logic [BW-1:0] d);
        #1;
        rst = r;
        data_valid = v;
        data_in = d;
    endtask

    task automatic drive(input logic r, input logic v, input logic [BW-1:0] d);
        @(negedge clk);
        apply(r, v, d);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (mq.size() == 0 && !m_active) break;
        end
        chk("idle_within_budget", 32'(i < 2000), 32'd1);
    endtask

    task automatic wait_cyc(input int t);
        for (int g = 0; g < 400; g++) begin
            if (cyc >= t) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n, fallc, bc, fb, dbase, lows, rate;

    initial begin
        rst = 1'b1;
        data_valid = 1'b0;
        data_in = '0;

        // Reset held with data_valid toggling.
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_empty", 32'(fifo_empty), 32'd1);
            chk("rst_drops", 32'(drop_count), 32'd0);
            apply(1'b1, ~data_valid, BW'(i + 7));
        end
        drive(1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);

        // Single word: start bit two cycles after the push, 40-cycle busy window.
        dbase = dec_q.size();
        drive(1'b0, 1'b1, 4'hA);
        n = cyc;
        drive(1'b0, 1'b0, '0);
        fallc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                fallc = cyc;
                break;
            end
        end
        chk("single_fall_cycle", 32'(fallc), 32'(n + 2));
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        chk("single_busy_len", 32'(bc), 32'd40);
        chk("single_byte", 32'(dec_at(dbase)), 32'(LIT_A));

        // Back-to-back frames with no idle gap.
        fb = fall_q.size();
        dbase = dec_q.size();
        drive(1'b0, 1'b1, 4'h3);
        drive(1'b0, 1'b1, 4'h5);
        drive(1'b0, 1'b0, '0);
        wait_idle();
        chk("b2b_gap", 32'(fall_at(fb + 1) - fall_at(fb)), 32'd40);
        chk("b2b_byte0", 32'(dec_at(dbase)), 32'(LIT_3));
        chk("b2b_byte1", 32'(dec_at(dbase + 1)), 32'(LIT_5));

        // Overflow, then a push on the last stop cycle while full.
        fb = fall_q.size();
        dbase = dec_q.size();
        drive(1'b0, 1'b1, 4'h1);
        n = cyc;
        for (int v = 2; v <= 7; v++) drive(1'b0, 1'b1, BW'(v));
        drive(1'b0, 1'b0, '0);
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_drops", 32'(drop_count), 32'd2);
        chk("ovf_fall_cycle", 32'(fall_at(fb)), 32'(n + 2));
        wait_cyc(fall_at(fb) + FLEN - 1);
        apply(1'b0, 1'b1, 4'h6);
        @(negedge clk);
        chk("pushpop_full", 32'(fifo_full), 32'd1);
        chk("pushpop_drops", 32'(drop_count), 32'd2);
        apply(1'b0, 1'b0, '0);
        wait_idle();
        for (int v = 1; v <= 6; v++)
            chk("ovf_order", 32'(dec_at(dbase + v - 1)), 32'(LIT_BASE + 8'(v)));

        // Reset during data bit 3 aborts the frame and empties the FIFO.
        fb = fall_q.size();
        drive(1'b0, 1'b1, 4'h9);
        drive(1'b0, 1'b1, 4'hC);
        drive(1'b0, 1'b0, '0);
        wait_cyc(fall_at(fb) + CPB * 4 + 1);
        apply(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_empty", 32'(fifo_empty), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        apply(1'b0, 1'b0, '0);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("midrst_no_frames", 32'(lows), 32'd0);

        // Random: heavy load to saturate the drop counter.
        for (int i = 0; i < 1500; i++)
            drive(1'b0, 1'($urandom_range(0, 9) != 0), BW'($urandom));
        drive(1'b0, 1'b0, '0);
        chk("drop_saturated", 32'(drop_count), 32'd255);

        // Random: varying load with occasional resets.
        rate = 1;
        for (int i = 0; i < 2500; i++) begin
            if (i % 200 == 0) rate = $urandom_range(0, 10);
            drive(1'($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 99) < rate * 6),
                  BW'($urandom));
        end
        drive(1'b0, 1'b0, '0);
        wait_idle();
        repeat (2) @(negedge clk);

        chk("stream_len", 32'(dec_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk("stream_byte", 32'(dec_at(i)), 32'(exp_q[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
